dl_ram_arbiter: RTL
===================

// Module: dl_ram_arbiter
// PURPOSE
//  Shares the single external RAM port between the SPI file-download write stream and the core's CPU.
//  Downloaded bytes are buffered in a small FIFO and relocated by menu index to a ROM or cartridge base.
//  The FIFO drains with priority over the CPU; the CPU is held off (cpu_hold) while a download is live.
//  Sits between the download receiver, the CPU bus and the RAM controller.
// PARAMETERS
//  FIFO_DEPTH  4           download write buffer entries, power of two, 2..16
//  ROM_BASE    25'h000000  RAM base for download index 0 (system ROM image)
//  CART_BASE   25'h010000  RAM base for any non-zero download index (cartridge image)
// PORTS
//  clk          in   1   core clock; all logic on posedge
//  reset        in   1   asynchronous, active-high reset
//  clkref       in   1   CPU cycle strobe; CPU requests are sampled only when high
//  dl_active    in   1   download in progress (synchronised to clk by the download receiver)
//  dl_wr        in   1   one-cycle byte-write strobe from the download receiver
//  dl_addr      in   25  byte offset within the file
//  dl_data      in   8   byte to write
//  dl_index     in   8   menu index of the file being loaded
//  cpu_req      in   1   CPU access request, level, held until cpu_ack
//  cpu_we       in   1   1 = write
//  cpu_addr     in   25  CPU RAM address
//  cpu_din      in   8   CPU write data
//  cpu_dout     out  8   CPU read data, valid with cpu_ack
//  cpu_ack      out  1   one-cycle completion pulse
//  cpu_hold     out  1   keep the core in reset / stalled
//  mem_req      out  1   RAM request, held until mem_ack
//  mem_we       out  1   RAM write enable
//  mem_addr     out  25  RAM address
//  mem_din      out  8   RAM write data
//  mem_dout     in   8   RAM read data, valid with mem_ack
//  mem_ack      in   1   one-cycle RAM completion pulse
//  load_done    out  1   one-cycle pulse once a download has fully drained to RAM
//  dl_overflow  out  1   sticky: a download byte was dropped (FIFO full); cleared by reset or a new dl_active rise
// BEHAVIOUR
//  Reset values: all outputs 0; FIFO empty; FSM in IDLE. Reset mid-transaction drops mem_req at once, and the RAM controller must tolerate this.
//  FIFO push on dl_wr: {dl_addr + base, dl_data}, where base = ROM_BASE if dl_index==0, else CART_BASE, truncated to 25 bits (wraps).
//  Full: push dropped and dl_overflow set, even if a pop happens in the same cycle. Push and pop in one cycle when not full: both occur and the count is unchanged.
//  FSM states:
//   - IDLE: if FIFO not empty -> DL_WR. Otherwise, if cpu_req && clkref && !cpu_hold -> CPU_ACC. The FIFO always wins a simultaneous request.
//   - DL_WR: mem_req=1, mem_we=1, head entry driven. On mem_ack, pop and go to IDLE.
//   - CPU_ACC: mem_req=1, cpu_we/cpu_addr/cpu_din are registered on entry. On mem_ack, cpu_ack=1 next cycle, cpu_dout=mem_dout (latched) -> IDLE.
//  No pre-emption once mem_req is asserted. One RAM access is outstanding at most.
//  Latency: dl_wr at cycle N -> mem_req at N+2 if IDLE. CPU request sampled at N -> mem_req at N+1.
//  cpu_hold: set on the dl_active rise. It clears together with the load_done pulse, which fires in the first cycle where dl_active=0, the FIFO is empty and the FSM is IDLE.
//  cpu_req is ignored while cpu_hold=1 and is never acked.
//  A new dl_active rise during the drain restarts hold, suppresses the pending load_done and clears dl_overflow.
// CONFIGURATION
//  DL_ARB_CHECKSUM_EN defined:
//   - adds output dl_checksum [7:0], the modulo-256 sum of all bytes pushed since the last dl_active rise (dropped bytes excluded).
//   - dl_checksum holds its value after load_done and resets to 0 on reset.
//  DL_ARB_CHECKSUM_EN undefined: the port and logic are absent.
// STRUCTURE
//  Package dl_arb_pkg: the FSM state enum (IDLE, DL_WR, CPU_ACC) and the FIFO entry struct {addr[24:0], data[7:0]}.
//  Sub-module dl_fifo: synchronous FIFO with parameterised depth, full/empty, same-cycle push/pop. The top level holds the FSM, relocation and hold/done logic.
// TESTING
//  1. dl_active rise, dl_index=0, dl_wr with addr 0x10, data 0xA5, mem_ack 2 cycles after mem_req
//     -> mem_addr=0x000010, mem_din=0xA5, mem_we=1; cpu_hold=1.
//  2. dl_index=3, write to addr 0x20 -> mem_addr=0x010020.
//     Drop dl_active with 2 entries queued -> both written, then load_done for one cycle and cpu_hold=0 on the same cycle.
//  3. mem_ack withheld, 5 dl_wr strobes with FIFO_DEPTH=4 -> 4 entries kept, dl_overflow=1; the 5th byte never appears on mem_*.
//  4. cpu_req (read, addr 0x1234) and dl_wr in the same cycle with clkref=1 -> download write first.
//     The CPU access then reads mem_dout=0x5A, giving a cpu_ack pulse with cpu_dout=0x5A.
//  5. reset asserted while in DL_WR with mem_req=1 -> mem_req=0 immediately; FIFO empty, cpu_hold=0 and dl_overflow=0 after release.
//  6. With DL_ARB_CHECKSUM_EN: push bytes 0xF0, 0x20, 0x01 -> dl_checksum=0x11 after load_done.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// Shared types for the download/CPU RAM arbiter: FSM states, FIFO entry layout
// and the download relocation helper.
package dl_arb_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DL_WR,
        CPU_ACC
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dl_entry_t;

    // Index 0 is the system ROM image; every other menu entry loads as a cartridge.
    function automatic logic [ADDR_W-1:0] dl_relocate(
        input logic [ADDR_W-1:0] offset,
        input logic [7:0]        index,
        input logic [ADDR_W-1:0] rom_base,
        input logic [ADDR_W-1:0] cart_base
    );
        return offset + ((index == 8'd0) ? rom_base : cart_base);
    endfunction

endpackage

// File: rtl/dl_ram_arbiter_if.sv
// Download, CPU and RAM-controller signals of dl_ram_arbiter; master is the arbiter side.
// DL_ARB_CHECKSUM_EN adds the dl_checksum output.
interface dl_ram_arbiter_if;
    import dl_arb_pkg::*;

    logic              clkref;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [DATA_W-1:0] dl_data;
    logic [7:0]        dl_index;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;
    logic              cpu_hold;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_ack;
    logic              load_done;
    logic              dl_overflow;
`ifdef DL_ARB_CHECKSUM_EN
    logic [7:0]        dl_checksum;
`endif

    modport master (
        input  clkref, dl_active, dl_wr, dl_addr, dl_data, dl_index,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_hold,
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack,
        output load_done, dl_overflow
`ifdef DL_ARB_CHECKSUM_EN
        , output dl_checksum
`endif
    );

    modport slave (
        output clkref, dl_active, dl_wr, dl_addr, dl_data, dl_index,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_hold,
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack,
        input  load_done, dl_overflow
`ifdef DL_ARB_CHECKSUM_EN
        , input dl_checksum
`endif
    );

endinterface

// File: rtl/dl_fifo.sv
// Synchronous download write buffer: power-of-two depth, push dropped when full,
// simultaneous push/pop supported.
module dl_fifo
    import dl_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  dl_entry_t din,
    output dl_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    dl_entry_t      store [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/dl_ram_arbiter.sv
// Shares one RAM port between the SPI download stream (buffered, relocated, priority)
// and the CPU. DL_ARB_CHECKSUM_EN adds a running byte checksum of the download.
module dl_ram_arbiter
    import dl_arb_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ROM_BASE   = 25'h000000,
    parameter logic [ADDR_W-1:0] CART_BASE  = 25'h010000
) (
    input logic              clk,
    input logic              reset,
    dl_ram_arbiter_if.master bus
);

    state_t            state;
    state_t            state_nxt;
    logic              dl_active_d;
    logic              dl_rise;
    dl_entry_t         push_entry;
    dl_entry_t         head;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_accept;
    logic              cpu_start;
    logic              cpu_take;
    logic              cpu_done;
    logic              drain_done;
    logic              cpu_we_r;
    logic [ADDR_W-1:0] cpu_addr_r;
    logic [DATA_W-1:0] cpu_din_r;
    logic [DATA_W-1:0] cpu_dout_r;
    logic              cpu_ack_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              overflow_r;
    logic              mem_req_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_din_c;

    assign dl_rise         = bus.dl_active && !dl_active_d;
    assign push_entry.addr = dl_relocate(bus.dl_addr, bus.dl_index, ROM_BASE, CART_BASE);
    assign push_entry.data = bus.dl_data;
    assign fifo_accept     = bus.dl_wr && !fifo_full;
    assign fifo_pop        = (state == DL_WR) && bus.mem_ack;
    assign cpu_done        = (state == CPU_ACC) && bus.mem_ack;

    // An incoming dl_wr blocks the CPU too, so a byte arriving with the request still wins.
    // The cpu_ack guard stops a request still held during its own ack cycle from re-issuing.
    assign cpu_start  = bus.cpu_req && bus.clkref && !cpu_hold_r && !cpu_ack_r && !bus.dl_wr;
    assign cpu_take   = (state == IDLE) && fifo_empty && cpu_start;
    assign drain_done = cpu_hold_r && !bus.dl_active && !bus.dl_wr && fifo_empty && (state == IDLE);

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.dl_wr),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_din_c  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty)    state_nxt = DL_WR;
                else if (cpu_start) state_nxt = CPU_ACC;
            end
            DL_WR: begin
                mem_req_c  = 1'b1;
                mem_we_c   = 1'b1;
                mem_addr_c = head.addr;
                mem_din_c  = head.data;
                if (bus.mem_ack) state_nxt = IDLE;
            end
            CPU_ACC: begin
                mem_req_c  = 1'b1;
                mem_we_c   = cpu_we_r;
                mem_addr_c = cpu_addr_r;
                mem_din_c  = cpu_din_r;
                if (bus.mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_we_r   <= 1'b0;
            cpu_addr_r <= '0;
            cpu_din_r  <= '0;
            cpu_dout_r <= '0;
            cpu_ack_r  <= 1'b0;
        end else begin
            if (cpu_take) begin
                cpu_we_r   <= bus.cpu_we;
                cpu_addr_r <= bus.cpu_addr;
                cpu_din_r  <= bus.cpu_din;
            end
            cpu_ack_r <= cpu_done;
            if (cpu_done) cpu_dout_r <= bus.mem_dout;
        end
    end

    // A rise mid-drain re-arms hold and cancels the pending done; a drop on that cycle still flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_active_d <= 1'b0;
            cpu_hold_r  <= 1'b0;
            load_done_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            dl_active_d <= bus.dl_active;
            load_done_r <= 1'b0;
            if (dl_rise) begin
                cpu_hold_r <= 1'b1;
            end else if (drain_done) begin
                cpu_hold_r  <= 1'b0;
                load_done_r <= 1'b1;
            end
            if (dl_rise)                  overflow_r <= 1'b0;
            if (bus.dl_wr && fifo_full)   overflow_r <= 1'b1;
        end
    end

`ifdef DL_ARB_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (dl_rise || fifo_accept) begin
            checksum <= (dl_rise ? 8'h00 : checksum) + (fifo_accept ? bus.dl_data : 8'h00);
        end
    end

    assign bus.dl_checksum = checksum;
`endif

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_din     = mem_din_c;
    assign bus.cpu_dout    = cpu_dout_r;
    assign bus.cpu_ack     = cpu_ack_r;
    assign bus.cpu_hold    = cpu_hold_r;
    assign bus.load_done   = load_done_r;
    assign bus.dl_overflow = overflow_r;

endmodule
